// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32I core pipeline.
//   - Writeback source select codes (WB_*).
//   - Load funct3 size/sign codes (F3_*).
//   - wb_ctrl_t: control fields carried by the MEM/WB pipeline register.
package riscv_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       regwr;
        logic [4:0] rd;
        logic [1:0] wbsel;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// load_extend: combinational load-data lane extraction and extension.
//   funct3  in  load size/sign code
//   addr_lo in  byte offset within the word
//   rdata   in  word read from data memory
//   value   out extracted, sign/zero-extended load value
//   fault   out misaligned access or unsupported load funct3
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value,
    output logic            fault
);

    logic [4:0]      sh;
    logic [XLEN-1:0] lane;

    assign sh   = {addr_lo, 3'b000};
    assign lane = rdata >> sh;

    always_comb begin
        value = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB:  value = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_LBU: value = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_LH: begin
                value = {{(XLEN-16){lane[15]}}, lane[15:0]};
                fault = addr_lo[0];
            end
            F3_LHU: begin
                value = {{(XLEN-16){1'b0}}, lane[15:0]};
                fault = addr_lo[0];
            end
            F3_LW: begin
                value = rdata;
                fault = (addr_lo != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback stage.
//   clk, rst_          clock, async active-low reset
//   stall, flush       hold WB / insert bubble (flush wins)
//   mem_*              instruction leaving MEM
//   dmem_rdata         synchronous data-memory word for the load in WB
//   wrtEn/Reg/Data     register-file write port
//   fwd_*              WB forwarding path (mirrors the write port)
//   load_fault         pulse on a misaligned/illegal load at retire
//   instret            retired-instruction counter
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_regwr,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_wbsel,
    input  logic [2:0]           mem_funct3,
    input  logic [1:0]           mem_addr_lo,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_pc4,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wrtEn,
    output logic [4:0]           wrtReg,
    output logic [XLEN-1:0]      wrtData,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 load_fault,
    output logic [INSTRET_W-1:0] instret
);

    wb_ctrl_t            ctrl_q, ctrl_d;
    logic [XLEN-1:0]     alu_result_q, alu_result_d;
    logic [XLEN-1:0]     pc4_q, pc4_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [XLEN-1:0]     ld_value;
    logic                ld_fault;
    logic                fault;
    logic                retire;

    // Flush takes priority over stall; the payload still loads on flush
    // since it is ignored once valid is cleared.
    always_comb begin
        ctrl_d       = ctrl_q;
        alu_result_d = alu_result_q;
        pc4_d        = pc4_q;
        if (flush || !stall) begin
            ctrl_d.valid   = mem_valid & ~flush;
            ctrl_d.regwr   = mem_regwr;
            ctrl_d.rd      = mem_rd;
            ctrl_d.wbsel   = mem_wbsel;
            ctrl_d.funct3  = mem_funct3;
            ctrl_d.addr_lo = mem_addr_lo;
            alu_result_d   = mem_alu_result;
            pc4_d          = mem_pc4;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ctrl_q       <= '0;
            alu_result_q <= '0;
            pc4_q        <= '0;
            instret_q    <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            alu_result_q <= alu_result_d;
            pc4_q        <= pc4_d;
            instret_q    <= instret_d;
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3  (ctrl_q.funct3),
        .addr_lo (ctrl_q.addr_lo),
        .rdata   (dmem_rdata),
        .value   (ld_value),
        .fault   (ld_fault)
    );

    // Non-load instructions reuse funct3/addr_lo for unrelated meanings,
    // so the load checks only matter when the write source is memory.
    assign fault  = (ctrl_q.wbsel == WB_MEM) & ld_fault;
    assign retire = ctrl_q.valid & ~stall;

    // Faulting loads still count as retired.
    assign instret_d = instret_q + INSTRET_W'(retire);

    always_comb begin
        wrtData = alu_result_q;
        case (ctrl_q.wbsel)
            WB_MEM:  wrtData = ld_value;
            WB_PC4:  wrtData = pc4_q;
            default: wrtData = alu_result_q;
        endcase
    end

    assign wrtEn      = retire & ctrl_q.regwr & (ctrl_q.rd != 5'd0) & ~fault;
    assign wrtReg     = ctrl_q.rd;
    assign load_fault = retire & fault;
    assign instret    = instret_q;

    assign fwd_valid  = wrtEn;
    assign fwd_rd     = wrtReg;
    assign fwd_data   = wrtData;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_;
    logic        stall, flush;
    logic        mem_valid, mem_regwr;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result, mem_pc4, dmem_rdata;
    logic        wrtEn, fwd_valid, load_fault;
    logic [4:0]  wrtReg, fwd_rd;
    logic [31:0] wrtData, fwd_data;
    logic [63:0] instret;

    int          n_chk, n_err;
    logic [63:0] exp_ir;

    mem_wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk(clk), .rst_(rst_), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_rd(mem_rd),
        .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
        .mem_alu_result(mem_alu_result), .mem_pc4(mem_pc4), .dmem_rdata(dmem_rdata),
        .wrtEn(wrtEn), .wrtReg(wrtReg), .wrtData(wrtData),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_fault(load_fault), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next WB cycle; inputs for that cycle applied 1ns after
    // the edge, then we settle to the negedge for checking.
    task automatic tick(input logic [31:0] rdata, input logic stl);
        @(posedge clk);
        #1;
        mem_valid  = 1'b0;
        flush      = 1'b0;
        stall      = stl;
        dmem_rdata = rdata;
        #4;
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                         input logic [2:0] f3, input logic [1:0] alo,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] rdata);
        mem_valid      = 1'b1;
        mem_regwr      = rw;
        mem_rd         = rd;
        mem_wbsel      = ws;
        mem_funct3     = f3;
        mem_addr_lo    = alo;
        mem_alu_result = alu;
        mem_pc4        = pc4;
        tick(rdata, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; exp_ir = 64'd0;
        rst_ = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; mem_regwr = 1'b0; mem_rd = 5'd0; mem_wbsel = WB_ALU;
        mem_funct3 = 3'b000; mem_addr_lo = 2'b00;
        mem_alu_result = 32'd0; mem_pc4 = 32'd0; dmem_rdata = 32'd0;
        #3;
        chk("rst_wrtEn", {63'd0, wrtEn}, 64'd0);
        chk("rst_wrtReg", {59'd0, wrtReg}, 64'd0);
        chk("rst_wrtData", {32'd0, wrtData}, 64'd0);
        chk("rst_fwd", {26'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
        chk("rst_fault", {63'd0, load_fault}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        #9 rst_ = 1'b1;

        // ALU op to x5
        issue(1'b1, 5'd5, WB_ALU, 3'b000, 2'b00, 32'h1234_5678, 32'h0000_0004, 32'd0);
        chk("alu_wrtEn", {63'd0, wrtEn}, 64'd1);
        chk("alu_wrtReg", {59'd0, wrtReg}, 64'd5);
        chk("alu_wrtData", {32'd0, wrtData}, 64'h1234_5678);
        chk("alu_fwd", {26'd0, fwd_valid, fwd_rd, fwd_data}, {26'd0, 1'b1, 5'd5, 32'h1234_5678});
        chk("alu_instret_pre", instret, exp_ir);
        exp_ir++;
        tick(32'd0, 1'b0);
        chk("alu_instret_post", instret, exp_ir);
        chk("bubble_wrtEn", {63'd0, wrtEn}, 64'd0);

        // LB / LBU, byte 3 of 0x80FF_0000 = 0x80
        issue(1'b1, 5'd6, WB_MEM, F3_LB, 2'd3, 32'h0000_1003, 32'd0, 32'h80FF_0000);
        chk("lb_data", {32'd0, wrtData}, 64'hFFFF_FF80);
        chk("lb_wrtEn", {63'd0, wrtEn}, 64'd1);
        chk("lb_fault", {63'd0, load_fault}, 64'd0);
        exp_ir++;
        issue(1'b1, 5'd6, WB_MEM, F3_LBU, 2'd3, 32'h0000_1003, 32'd0, 32'h80FF_0000);
        chk("lbu_data", {32'd0, wrtData}, 64'h0000_0080);
        exp_ir++;

        // LH misaligned: suppressed write, one-cycle fault pulse
        issue(1'b1, 5'd7, WB_MEM, F3_LH, 2'd1, 32'h0000_2001, 32'd0, 32'h1234_5678);
        chk("lh_mis_wrtEn", {63'd0, wrtEn}, 64'd0);
        chk("lh_mis_fault", {63'd0, load_fault}, 64'd1);
        exp_ir++;
        tick(32'd0, 1'b0);
        chk("lh_mis_fault_end", {63'd0, load_fault}, 64'd0);
        chk("lh_mis_instret", instret, exp_ir);

        // LHU upper half, LH sign, LW
        issue(1'b1, 5'd8, WB_MEM, F3_LHU, 2'd2, 32'h0000_2002, 32'd0, 32'h8001_1234);
        chk("lhu_data", {32'd0, wrtData}, 64'h0000_8001);
        chk("lhu_wrtEn", {63'd0, wrtEn}, 64'd1);
        exp_ir++;
        issue(1'b1, 5'd8, WB_MEM, F3_LH, 2'd2, 32'h0000_2002, 32'd0, 32'h8001_1234);
        chk("lh_data", {32'd0, wrtData}, 64'hFFFF_8001);
        exp_ir++;
        issue(1'b1, 5'd9, WB_MEM, F3_LW, 2'd0, 32'h0000_3000, 32'd0, 32'hDEAD_BEEF);
        chk("lw_data", {32'd0, wrtData}, 64'hDEAD_BEEF);
        exp_ir++;
        issue(1'b1, 5'd9, WB_MEM, F3_LW, 2'd2, 32'h0000_3002, 32'd0, 32'hDEAD_BEEF);
        chk("lw_mis", {62'd0, wrtEn, load_fault}, 64'd1);
        exp_ir++;
        issue(1'b1, 5'd9, WB_MEM, 3'b011, 2'd0, 32'h0000_3000, 32'd0, 32'hDEAD_BEEF);
        chk("f3_illegal", {62'd0, wrtEn, load_fault}, 64'd1);
        exp_ir++;

        // PC4 writeback and the reserved 11 select
        issue(1'b1, 5'd1, WB_PC4, 3'b000, 2'd0, 32'h0000_00AA, 32'h0000_0104, 32'd0);
        chk("pc4_data", {32'd0, wrtData}, 64'h0000_0104);
        exp_ir++;
        issue(1'b1, 5'd1, 2'b11, 3'b000, 2'd0, 32'h0000_00AA, 32'h0000_0104, 32'd0);
        chk("ws11_data", {32'd0, wrtData}, 64'h0000_00AA);
        exp_ir++;

        // x0 write suppressed but still retires
        issue(1'b1, 5'd0, WB_ALU, 3'b000, 2'd0, 32'h5555_5555, 32'd0, 32'd0);
        chk("x0_wrtEn", {63'd0, wrtEn}, 64'd0);
        exp_ir++;
        tick(32'd0, 1'b0);
        chk("x0_instret", instret, exp_ir);

        // 3-cycle stall: retire exactly once, after the stall
        issue(1'b1, 5'd10, WB_ALU, 3'b000, 2'd0, 32'hA5A5_A5A5, 32'd0, 32'd0);
        stall = 1'b1;
        #1;
        chk("stall_wrtEn_0", {63'd0, wrtEn}, 64'd0);
        tick(32'd0, 1'b1);
        chk("stall_wrtEn_1", {63'd0, wrtEn}, 64'd0);
        tick(32'd0, 1'b1);
        chk("stall_wrtEn_2", {63'd0, wrtEn}, 64'd0);
        chk("stall_instret", instret, exp_ir);
        tick(32'd0, 1'b0);
        chk("stall_release", {27'd0, wrtEn, wrtReg, wrtData}, {27'd0, 1'b1, 5'd10, 32'hA5A5_A5A5});
        exp_ir++;
        tick(32'd0, 1'b0);
        chk("stall_once", {63'd0, wrtEn}, 64'd0);
        chk("stall_instret_post", instret, exp_ir);

        // flush + stall together: bubble enters WB
        mem_valid = 1'b1; mem_regwr = 1'b1; mem_rd = 5'd11; mem_wbsel = WB_ALU;
        mem_funct3 = 3'b000; mem_addr_lo = 2'd0; mem_alu_result = 32'h0BAD_0BAD;
        flush = 1'b1; stall = 1'b1;
        tick(32'd0, 1'b0);
        chk("flush_wrtEn", {63'd0, wrtEn}, 64'd0);
        tick(32'd0, 1'b0);
        chk("flush_instret", instret, exp_ir);

        // reset pulsed mid-stall discards the held instruction
        issue(1'b1, 5'd12, WB_ALU, 3'b000, 2'd0, 32'h0C0C_0C0C, 32'd0, 32'd0);
        stall = 1'b1;
        #1;
        rst_ = 1'b0;
        #1;
        chk("rst_stall_wrtEn", {63'd0, wrtEn}, 64'd0);
        chk("rst_stall_instret", instret, 64'd0);
        exp_ir = 64'd0;
        rst_ = 1'b1;
        stall = 1'b0;
        tick(32'd0, 1'b0);
        chk("post_rst_wrtEn", {63'd0, wrtEn}, 64'd0);
        tick(32'd0, 1'b0);
        chk("post_rst_instret", instret, 64'd0);

        // next instruction retires normally
        issue(1'b1, 5'd13, WB_ALU, 3'b000, 2'd0, 32'h1357_9BDF, 32'd0, 32'd0);
        chk("after_rst_write", {27'd0, wrtEn, wrtReg, wrtData}, {27'd0, 1'b1, 5'd13, 32'h1357_9BDF});
        exp_ir++;
        tick(32'd0, 1'b0);
        chk("after_rst_instret", instret, exp_ir);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
